// File: rtl/pwm_capture.sv
// PWM input measurement: synchronises pwm_in, then reports high time and period
// (rising edge to rising edge, in clk cycles) with a valid strobe and stuck-input flags.
module pwm_capture #(
  parameter int PWM_CNT     = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pwm_in,
  output logic [PWM_CNT:0]   high_cnt,
  output logic [PWM_CNT:0]   period_cnt,
  output logic               valid,
  output logic               locked,
  output logic               stuck_hi,
  output logic               stuck_lo
);

  localparam int CNT_W = PWM_CNT + 1;
  localparam logic [CNT_W-1:0] MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    WAIT_LOW  = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_dly_q;
  logic [CNT_W-1:0]       pcnt_q, pcnt_d;
  logic [CNT_W-1:0]       hcnt_q, hcnt_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   locked_q, locked_d;
  logic                   stuck_hi_q, stuck_hi_d;
  logic                   stuck_lo_q, stuck_lo_d;
  logic                   s_s, rise_s, fall_s, timeout_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == MAX) ? MAX : v + ONE;
  endfunction

  assign s_s       = sync_q[SYNC_STAGES-1];
  assign rise_s    = s_s & ~s_dly_q;
  assign fall_s    = ~s_s & s_dly_q;
  // A rise arriving exactly at saturation still closes the period normally.
  assign timeout_s = (pcnt_q == MAX) && !rise_s;

  // Next-state, counter and measurement-output logic.
  always_comb begin
    state_d    = state_q;
    pcnt_d     = sat_inc(pcnt_q);
    hcnt_d     = hcnt_q;
    high_d     = high_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    locked_d   = locked_q;
    stuck_hi_d = stuck_hi_q;
    stuck_lo_d = stuck_lo_q;
    if (timeout_s) begin
      stuck_hi_d = s_s;
      stuck_lo_d = ~s_s;
      locked_d   = 1'b0;
      high_d     = ZERO;
      period_d   = ZERO;
      pcnt_d     = MAX;
      state_d    = s_s ? WAIT_LOW : WAIT_RISE;
    end else begin
      case (state_q)
        WAIT_LOW: begin
          if (!s_s) state_d = WAIT_RISE;
          else      state_d = WAIT_LOW;
        end
        WAIT_RISE: begin
          if (rise_s) begin
            state_d    = HIGH;
            pcnt_d     = ONE;
            hcnt_d     = ONE;
            stuck_hi_d = 1'b0;
            stuck_lo_d = 1'b0;
          end else begin
            state_d = WAIT_RISE;
          end
        end
        HIGH: begin
          if (fall_s) begin
            state_d = LOW;
          end else begin
            state_d = HIGH;
            hcnt_d  = sat_inc(hcnt_q);
          end
        end
        LOW: begin
          if (rise_s) begin
            state_d    = HIGH;
            period_d   = pcnt_q;
            high_d     = hcnt_q;
            valid_d    = 1'b1;
            locked_d   = 1'b1;
            stuck_hi_d = 1'b0;
            stuck_lo_d = 1'b0;
            pcnt_d     = ONE;
            hcnt_d     = ONE;
          end else begin
            state_d = LOW;
          end
        end
        default: state_d = WAIT_LOW;
      endcase
    end
  end

  // Synchroniser, edge-detect delay and all state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= {SYNC_STAGES{1'b0}};
      s_dly_q    <= 1'b0;
      state_q    <= WAIT_LOW;
      pcnt_q     <= ZERO;
      hcnt_q     <= ZERO;
      high_q     <= ZERO;
      period_q   <= ZERO;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      stuck_hi_q <= 1'b0;
      stuck_lo_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_dly_q    <= s_s;
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      hcnt_q     <= hcnt_d;
      high_q     <= high_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      stuck_hi_q <= stuck_hi_d;
      stuck_lo_q <= stuck_lo_d;
    end
  end

  assign high_cnt   = high_q;
  assign period_cnt = period_q;
  assign valid      = valid_q;
  assign locked     = locked_q;
  assign stuck_hi   = stuck_hi_q;
  assign stuck_lo   = stuck_lo_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: PWM-generator and random waveforms
// compared cycle by cycle against a timestamp-based reference model.
module tb_pwm_capture;

  localparam int PWM_CNT = 4;
  localparam int SYNC    = 2;
  localparam int CNT_W   = PWM_CNT + 1;
  localparam int MAX     = (1 << CNT_W) - 1;
  localparam int GEN_PER = 1 << PWM_CNT;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] high_cnt, period_cnt;
  logic             valid, locked, stuck_hi, stuck_lo;

  pwm_capture #(.PWM_CNT(PWM_CNT), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .high_cnt(high_cnt), .period_cnt(period_cnt), .valid(valid),
    .locked(locked), .stuck_hi(stuck_hi), .stuck_lo(stuck_lo)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: measurements derived from edge timestamps of the
  // synchronised input, which is a pure SYNC-cycle delay of what we drive.
  logic dl[$];
  int   t, base, rise_t, fall_t;
  bit   have_rise;
  logic prev_s;
  int   exp_high, exp_period;
  bit   exp_valid, exp_locked, exp_shi, exp_slo;
  int   gen_cnt = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    t = 0; base = 0; rise_t = 0; fall_t = -1; have_rise = 1'b0; prev_s = 1'b0;
    exp_high = 0; exp_period = 0;
    exp_valid = 1'b0; exp_locked = 1'b0; exp_shi = 1'b0; exp_slo = 1'b0;
    dl = {};
    for (int i = 0; i < SYNC; i++) dl.push_back(1'b0);
  endtask

  task automatic model_step(input logic s);
    logic rise, fall;
    int   age;
    rise = s & ~prev_s;
    fall = ~s & prev_s;
    age  = t - base;
    if (age > MAX) age = MAX;
    exp_valid = 1'b0;
    if (rise) begin
      if (have_rise) begin
        exp_valid  = 1'b1;
        exp_period = t - rise_t;
        exp_high   = fall_t - rise_t;
        exp_locked = 1'b1;
      end
      exp_shi = 1'b0; exp_slo = 1'b0;
      have_rise = 1'b1; rise_t = t; base = t; fall_t = -1;
    end else if (age == MAX) begin
      exp_shi = s; exp_slo = ~s; exp_locked = 1'b0;
      exp_high = 0; exp_period = 0; have_rise = 1'b0;
    end else if (fall && fall_t < 0) begin
      fall_t = t;
    end
    prev_s = s;
    t++;
  endtask

  task automatic check_outputs();
    check_eq("valid",    int'(valid),      int'(exp_valid));
    check_eq("locked",   int'(locked),     int'(exp_locked));
    check_eq("stuck_hi", int'(stuck_hi),   int'(exp_shi));
    check_eq("stuck_lo", int'(stuck_lo),   int'(exp_slo));
    check_eq("high_cnt", int'(high_cnt),   exp_high);
    check_eq("period",   int'(period_cnt), exp_period);
  endtask

  // One clock interval: check, advance model, drive next input sample.
  task automatic tick(input logic v);
    logic s;
    check_outputs();
    s = dl.pop_front();
    model_step(s);
    pwm_in = v;
    dl.push_back(v);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    #1;
    check_eq("rst_valid",  int'(valid),      0);
    check_eq("rst_locked", int'(locked),     0);
    check_eq("rst_shi",    int'(stuck_hi),   0);
    check_eq("rst_slo",    int'(stuck_lo),   0);
    check_eq("rst_high",   int'(high_cnt),   0);
    check_eq("rst_period", int'(period_cnt), 0);
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic gen_run(input int cmp, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick((gen_cnt < cmp) ? 1'b1 : 1'b0);
      gen_cnt = (gen_cnt + 1) % GEN_PER;
    end
  endtask

  task automatic level_run(input logic v, input int cycles);
    for (int i = 0; i < cycles; i++) tick(v);
  endtask

  initial begin
    int hi_len, lo_len;
    #2;
    pwm_in = 1'b0;
    do_reset(3);
    gen_cnt = 0;
    gen_run(5, 20 * GEN_PER);
    check_eq("t1_high", int'(high_cnt), 5);
    check_eq("t1_period", int'(period_cnt), GEN_PER);
    check_eq("t1_locked", int'(locked), 1);

    gen_run(15, 8 * GEN_PER);
    check_eq("t2_high15", int'(high_cnt), 15);
    gen_run(1, 8 * GEN_PER);
    check_eq("t2_high1", int'(high_cnt), 1);
    check_eq("t2_period", int'(period_cnt), GEN_PER);

    pwm_in = 1'b0;
    do_reset(2);
    gen_cnt = 0;
    gen_run(0, 60);
    check_eq("t3_stuck_lo", int'(stuck_lo), 1);
    check_eq("t3_locked", int'(locked), 0);
    gen_run(8, 6 * GEN_PER);
    check_eq("t3_high", int'(high_cnt), 8);
    check_eq("t3_stuck_lo_clr", int'(stuck_lo), 0);

    pwm_in = 1'b1;
    do_reset(2);
    level_run(1'b1, 80);
    check_eq("t4_stuck_hi", int'(stuck_hi), 1);
    check_eq("t4_locked", int'(locked), 0);
    level_run(1'b0, 5);
    gen_cnt = 0;
    gen_run(3, 6 * GEN_PER);
    check_eq("t4_high", int'(high_cnt), 3);

    for (int k = 0; k < 12; k++) begin
      gen_run(5, $urandom_range(GEN_PER, 3 * GEN_PER));
      gen_run(10, $urandom_range(GEN_PER, 3 * GEN_PER));
    end

    gen_run(12, 4 * GEN_PER);
    while (gen_cnt != 4) gen_run(12, 1);
    do_reset(2);
    gen_run(12, 6 * GEN_PER);
    check_eq("t6_high", int'(high_cnt), 12);

    for (int k = 0; k < 80; k++) begin
      hi_len = ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(1, 18);
      lo_len = ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(1, 18);
      level_run(1'b1, hi_len);
      level_run(1'b0, lo_len);
      if ($urandom_range(0, 29) == 0) do_reset($urandom_range(1, 3));
    end
    gen_cnt = 0;
    gen_run($urandom_range(1, GEN_PER - 1), 6 * GEN_PER);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
